// File: rtl/amo_sequencer.sv
// Atomic memory op sequencer: LR/SC and AMO read-modify-write on the data port.
// Owns the single LR reservation, invalidated by SC, snoop hit or timeout.
module amo_sequencer #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int RSV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        alu_control,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SWAP = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_MIN  = 4'd5;
    localparam logic [3:0] ALU_MAX  = 4'd6;
    localparam logic [3:0] ALU_LR   = 4'd7;
    localparam logic [3:0] ALU_SC   = 4'd8;

    localparam int CW = $clog2(RSV_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(RSV_TIMEOUT);
    localparam logic [ADDR_W-1:0] WMASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic              err_q, err_d;
    logic              rsv_valid_q, rsv_valid_d;
    logic [ADDR_W-1:0] rsv_addr_q, rsv_addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [3:0] op_in;
    logic       accept;
    logic       misaligned;
    logic       sc_ok;

    function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return ((a ^ b) & WMASK) == '0;
    endfunction

    function automatic logic [XLEN-1:0] amo_f(input logic [3:0]      op,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] rs2);
        case (op)
            ALU_SWAP: return rs2;
            ALU_AND:  return old & rs2;
            ALU_OR:   return old | rs2;
            ALU_XOR:  return old ^ rs2;
            ALU_MIN:  return ($signed(old) < $signed(rs2)) ? old : rs2;
            ALU_MAX:  return ($signed(old) > $signed(rs2)) ? old : rs2;
            default:  return old + rs2;
        endcase
    endfunction

    always_comb begin
        case (alu_control)
            ALU_ADD, ALU_SWAP, ALU_AND, ALU_OR, ALU_XOR,
            ALU_MIN, ALU_MAX, ALU_LR, ALU_SC: op_in = alu_control;
            default:                          op_in = ALU_ADD;
        endcase
    end

    assign accept     = (state_q == S_IDLE) && start;
    assign misaligned = addr[1:0] != 2'b00;
    assign sc_ok      = rsv_valid_q && same_word(addr, rsv_addr_q) &&
                        !(snoop_valid && same_word(snoop_addr, addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            rs2_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_addr_q  <= rsv_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (misaligned)         state_d = S_DONE;
                    else if (op_in == ALU_SC) state_d = sc_ok ? S_WRITE : S_DONE;
                    else                    state_d = S_READ;
                end
            end
            S_READ:  if (mem_ready) state_d = (op_q == ALU_LR) ? S_DONE : S_WRITE;
            S_WRITE: if (mem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op_in;
                    addr_d = addr & WMASK;
                    rs2_d  = rs2_data;
                    err_d  = misaligned;
                    if (misaligned) begin
                        rd_d = '0;
                    end else if (op_in == ALU_SC) begin
                        if (sc_ok) wdata_d = rs2_data;
                        else       rd_d    = XLEN'(1);
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    rd_d = mem_rdata;
                    if (op_q != ALU_LR) wdata_d = amo_f(op_q, mem_rdata, rs2_q);
                end
            end
            S_WRITE: if (mem_ready && op_q == ALU_SC) rd_d = '0;
            S_DONE:  ;
        endcase
    end

    // Later assignments take priority: an LR landing with a matching snoop stays invalid.
    always_comb begin
        rsv_valid_d = rsv_valid_q;
        rsv_addr_d  = rsv_addr_q;
        cnt_d       = cnt_q;
        if (rsv_valid_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == TMO) rsv_valid_d = 1'b0;
        end
        if (snoop_valid && same_word(snoop_addr, rsv_addr_q)) rsv_valid_d = 1'b0;
        if (accept && op_in == ALU_SC) rsv_valid_d = 1'b0;
        if (state_q == S_READ && mem_ready && op_q == ALU_LR) begin
            rsv_addr_d  = addr_q;
            cnt_d       = '0;
            rsv_valid_d = !(snoop_valid && same_word(snoop_addr, addr_q));
        end
    end

    always_comb begin
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE:  busy = 1'b0;
            S_READ:  mem_req = 1'b1;
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
        endcase
    end

    assign rd_data   = rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: directed scenarios then random ops against a
// transaction-level model of memory, reservation and latency.
module tb_amo_sequencer;

    localparam int XLEN        = 32;
    localparam int ADDR_W      = 32;
    localparam int RSV_TIMEOUT = 64;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SWAP = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_MIN  = 4'd5;
    localparam logic [3:0] C_MAX  = 4'd6;
    localparam logic [3:0] C_LR   = 4'd7;
    localparam logic [3:0] C_SC   = 4'd8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [3:0]        alu_control;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   rs2_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [XLEN-1:0]   rd_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ready;
    logic [XLEN-1:0]   mem_rdata;
    logic              snoop_valid;
    logic [ADDR_W-1:0] snoop_addr;

    amo_sequencer #(
        .XLEN(XLEN),
        .ADDR_W(ADDR_W),
        .RSV_TIMEOUT(RSV_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .alu_control(alu_control),
        .addr(addr),
        .rs2_data(rs2_data),
        .busy(busy),
        .done(done),
        .err(err),
        .rd_data(rd_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory environment (written only by the responder) and the reference model.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [64:0] acc_q [$];
    logic [64:0] exp_q [$];
    int          stall_r = 0;
    int          stall_w = 0;
    logic [8:0]  poke_w = 9'h100;
    logic [31:0] poke_v = 0;

    bit          rv = 0;
    logic [31:0] rw = 0;
    int          rset = 0;

    task automatic responder();
        int          wcnt;
        bit          prev_wait;
        logic [64:0] prev_req;
        wcnt      = 0;
        prev_wait = 0;
        prev_req  = '0;
        forever begin
            @(negedge clk);
            if (!poke_w[8]) begin
                mem[poke_w[7:0]] = poke_v;
                poke_w = 9'h100;
            end
            if (mem_req && !reset) begin
                if (prev_wait)
                    chk("req_stable", 96'({mem_we, mem_addr, mem_wdata}), 96'(prev_req));
                if (wcnt >= (mem_we ? stall_w : stall_r)) begin
                    mem_ready = 1'b1;
                    acc_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0});
                    if (mem_we) begin
                        mem[mem_addr[9:2]] = mem_wdata;
                        mem_rdata = 32'hDEAD_BEEF;
                    end else begin
                        mem_rdata = mem[mem_addr[9:2]];
                    end
                    wcnt      = 0;
                    prev_wait = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                    prev_wait = 1;
                    prev_req  = {mem_we, mem_addr, mem_wdata};
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
                prev_wait = 0;
            end
        end
    endtask

    function automatic logic [31:0] f_amo(input logic [3:0] c, input logic [31:0] o,
                                          input logic [31:0] r);
        case (c)
            C_SWAP:  return r;
            C_AND:   return o & r;
            C_OR:    return o | r;
            C_XOR:   return o ^ r;
            C_MIN:   return ($signed(o) < $signed(r)) ? o : r;
            C_MAX:   return ($signed(o) > $signed(r)) ? o : r;
            default: return o + r;
        endcase
    endfunction

    task automatic setmem(input logic [7:0] w, input logic [31:0] v);
        ref_mem[w] = v;
        poke_v     = v;
        poke_w     = {1'b0, w};
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit snp, input logic [31:0] sa);
        for (int i = 0; i < n; i++) begin
            snoop_valid = snp && (i == 0);
            snoop_addr  = sa;
            if (snoop_valid && rv && sa[31:2] == rw[31:2]) rv = 0;
            @(negedge clk);
        end
        snoop_valid = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] rs2, input int sr, input int sw,
                         input bit snp, input logic [31:0] sa, input bit hold);
        int          acc;
        int          lat;
        int          k;
        int          n;
        logic [31:0] erd;
        logic [31:0] old;
        logic [31:0] nv;
        logic [3:0]  c;
        bit          eerr;
        bit          ok;
        chk("idle_before", 96'(busy), 96'(0));
        stall_r = sr;
        stall_w = sw;
        acc_q.delete();
        exp_q.delete();
        acc  = cyc + 1;
        c    = (code > C_SC) ? C_ADD : code;
        eerr = 0;
        erd  = 0;
        lat  = 1;
        if (snp && rv && sa[31:2] == rw[31:2]) rv = 0;
        if (a[1:0] != 2'b00) begin
            eerr = 1;
            if (c == C_SC) rv = 0;
        end else if (c == C_SC) begin
            ok = rv && rw[31:2] == a[31:2] && (acc - rset <= RSV_TIMEOUT);
            rv = 0;
            if (ok) begin
                lat = 2 + sw;
                exp_q.push_back({1'b1, a, rs2});
                ref_mem[a[9:2]] = rs2;
            end else begin
                erd = 1;
            end
        end else if (c == C_LR) begin
            erd  = ref_mem[a[9:2]];
            lat  = 2 + sr;
            exp_q.push_back({1'b0, a, 32'h0});
            rv   = 1;
            rw   = a;
            rset = acc + 1 + sr;
        end else begin
            old = ref_mem[a[9:2]];
            nv  = f_amo(c, old, rs2);
            erd = old;
            lat = 3 + sr + sw;
            exp_q.push_back({1'b0, a, 32'h0});
            exp_q.push_back({1'b1, a, nv});
            ref_mem[a[9:2]] = nv;
        end
        start       = 1'b1;
        alu_control = code;
        addr        = a;
        rs2_data    = rs2;
        snoop_valid = snp;
        snoop_addr  = sa;
        @(negedge clk);
        snoop_valid = 1'b0;
        if (hold) begin
            alu_control = C_SWAP;
            addr        = a ^ 32'h10;
            rs2_data    = ~rs2;
        end else begin
            start = 1'b0;
        end
        k = 1;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("latency", 96'(k), 96'(lat));
        chk("rd_data", 96'(rd_data), 96'(erd));
        chk("err", 96'(err), 96'(eerr));
        chk("n_access", 96'(acc_q.size()), 96'(exp_q.size()));
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("access", 96'(acc_q[i]), 96'(exp_q[i]));
        @(negedge clk);
        chk("done_pulse", 96'({done, err, busy}), 96'(0));
        chk("rd_hold", 96'(rd_data), 96'(erd));
    endtask

    function automatic logic [31:0] pool_addr();
        int s;
        s = $urandom_range(0, 8);
        return (s == 8) ? 32'h200 : 32'h100 + 32'(4 * s);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          r;
        int          g;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] last_lr;
        logic [31:0] sa;
        bit          snp;
        logic [31:0] v;

        reset       = 1'b1;
        start       = 1'b0;
        alu_control = '0;
        addr        = '0;
        rs2_data    = '0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        for (int i = 0; i < 256; i++) begin
            v          = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        fork
            responder();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_ctl", 96'({busy, done, err, mem_req, mem_we}), 96'(0));
        chk("rst_rd", 96'(rd_data), 96'(0));
        chk("rst_maddr", 96'(mem_addr), 96'(0));
        chk("rst_wdata", 96'(mem_wdata), 96'(0));
        reset = 1'b0;
        @(negedge clk);

        setmem(8'h40, 32'd5);
        do_op(C_ADD, 32'h100, 32'd3, 0, 0, 0, 0, 0);
        chk("t1_mem", 96'(mem[8'h40]), 96'(8));

        setmem(8'h41, 32'hFFFF_FFFF);
        do_op(C_MIN, 32'h104, 32'd1, 0, 0, 0, 0, 0);
        chk("t2_min_mem", 96'(mem[8'h41]), 96'(32'hFFFF_FFFF));
        do_op(C_MAX, 32'h104, 32'd1, 0, 0, 0, 0, 0);
        chk("t2_max_mem", 96'(mem[8'h41]), 96'(1));

        setmem(8'h80, 32'd7);
        do_op(C_LR, 32'h200, 32'd0, 0, 0, 0, 0, 0);
        do_op(C_SC, 32'h200, 32'hAA, 0, 0, 0, 0, 0);
        chk("t3_sc_mem", 96'(mem[8'h80]), 96'(32'hAA));
        do_op(C_SC, 32'h200, 32'hBB, 0, 0, 0, 0, 0);

        do_op(C_LR, 32'h200, 32'd0, 0, 0, 0, 0, 0);
        idle(1, 1, 32'h202);
        do_op(C_SC, 32'h200, 32'h11, 0, 0, 0, 0, 0);
        do_op(C_LR, 32'h200, 32'd0, 0, 0, 0, 0, 0);
        idle(RSV_TIMEOUT, 0, 0);
        do_op(C_SC, 32'h200, 32'h22, 0, 0, 0, 0, 0);

        do_op(C_ADD, 32'h108, 32'h5, 4, 0, 0, 0, 1);

        do_op(C_LR, 32'h200, 32'd0, 0, 0, 0, 0, 0);
        stall_r     = 0;
        stall_w     = 10;
        start       = 1'b1;
        alu_control = C_SC;
        addr        = 32'h200;
        rs2_data    = 32'h55;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!mem_we && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_in_write", 96'(mem_we), 96'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", 96'(mem_req), 96'(0));
        chk("t6_rst_busy", 96'(busy), 96'(0));
        reset   = 1'b0;
        rv      = 0;
        stall_w = 0;
        do_op(C_SC, 32'h200, 32'h66, 0, 0, 0, 0, 0);
        chk("t6_mem", 96'(mem[8'h80]), 96'(ref_mem[8'h80]));
        do_op(C_ADD, 32'h102, 32'd1, 0, 0, 0, 0, 0);

        last_lr = 32'h200;
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 19);
            if (r < 9)       code = 4'(r);
            else if (r < 13) code = C_LR;
            else if (r < 17) code = C_SC;
            else             code = 4'($urandom_range(9, 15));
            a = pool_addr();
            if (code == C_SC && $urandom_range(0, 9) < 7) a = last_lr;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            if (code == C_LR && a[1:0] == 2'b00) last_lr = a;
            snp = $urandom_range(0, 5) == 0;
            sa  = pool_addr() | 32'($urandom_range(0, 3));
            do_op(code, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  snp, sa, $urandom_range(0, 7) == 0);
            g = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) g = ($urandom_range(0, 1) == 1) ? 40 : 70;
            idle(g, $urandom_range(0, 3) == 0, pool_addr() | 32'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
